// File: rtl/sdram_wfifo_feeder_pkg.sv
// Shared definitions for the SDRAM write-path feeder: default byte width and
// the one-hot trigger FSM state encoding.
package sdram_wfifo_feeder_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_TRIG = 3'b010,
        S_BUSY = 3'b100
    } state_e;

endpackage

// File: rtl/sdram_wfifo_feeder_fifo.sv
// Synchronous single-clock byte FIFO with occupancy count, registered read
// data and sticky overflow/underflow flags. Full/empty come from the count,
// so pointers may wrap freely without an extra wrap bit.
module sdram_wfifo_feeder_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_req,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_rdy,
    input  logic              pop_req,
    output logic              pop_ok,
    output logic [DATA_W-1:0] pop_data,
    output logic [AW:0]       cnt,
    output logic              ovf_err,
    output logic              udf_err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              full, empty, push_ok;

    // Next-state for pointers, count, read data and sticky error flags.
    // Acceptance uses the pre-pop count, so a push into a full FIFO is
    // rejected even when a pop happens on the same edge.
    always_comb begin
        full      = (cnt_q == (AW+1)'(DEPTH));
        empty     = (cnt_q == '0);
        push_ok   = push_req & ~full;
        pop_ok    = pop_req & ~empty;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q | (push_req & full);
        udf_d = udf_q | (pop_req & empty);
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage array; contents are don't-care after reset since count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign push_rdy = ~full;
    assign pop_data = rd_data_q;
    assign cnt      = cnt_q;
    assign ovf_err  = ovf_q;
    assign udf_err  = udf_q;

endmodule

// File: rtl/sdram_wfifo_feeder.sv
// Upstream stage of the SDRAM write path: buffers an incoming byte stream and
// pulses wr_trig once per buffered burst, then serves the write engine's pops
// until that burst has been drained.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for at least BURST_LEN bytes in the FIFO
//   S_TRIG | wr_trig high for this single cycle; burst counter cleared
//   S_BUSY | counting engine pops; back to S_IDLE after BURST_LEN pops
//
// Pops taken outside S_BUSY still read the FIFO but are not counted. DEPTH
// must be a power of two and at least 2*BURST_LEN.
module sdram_wfifo_feeder
    import sdram_wfifo_feeder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_vld,
    input  logic [DATA_W-1:0] din,
    output logic              din_rdy,
    output logic              wr_trig,
    input  logic              wfifo_rd_en,
    output logic [DATA_W-1:0] wfifo_rd_data,
    output logic [AW:0]       fifo_cnt,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int BCW = $clog2(BURST_LEN + 1);

    state_e         state_q, state_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           wr_trig_q, wr_trig_d;
    logic           pop_ok;

    sdram_wfifo_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_req  (din_vld),
        .push_data (din),
        .push_rdy  (din_rdy),
        .pop_req   (wfifo_rd_en),
        .pop_ok    (pop_ok),
        .pop_data  (wfifo_rd_data),
        .cnt       (fifo_cnt),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
    );

    // Trigger FSM next-state and burst counting.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (fifo_cnt >= (AW+1)'(BURST_LEN)) begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                burst_cnt_d = '0;
                state_d     = S_BUSY;
            end
            S_BUSY: begin
                if (pop_ok) begin
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                    if (burst_cnt_q == BCW'(BURST_LEN - 1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                burst_cnt_d = '0;
            end
        endcase
        // Registered pulse: high exactly while the FSM sits in S_TRIG.
        wr_trig_d = (state_d == S_TRIG);
    end

    // FSM state, burst counter and trigger register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            wr_trig_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            wr_trig_q   <= wr_trig_d;
        end
    end

    assign wr_trig = wr_trig_q;

endmodule

// File: tb/tb_sdram_wfifo_feeder.sv
// Directed bench for sdram_wfifo_feeder: burst trigger timing, read latency,
// overflow/underflow, pointer wrap and asynchronous reset mid-burst.
module tb_sdram_wfifo_feeder;
    import sdram_wfifo_feeder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_vld = 1'b0;
    logic [7:0] din = 8'h00;
    logic       wfifo_rd_en = 1'b0;
    logic       din_rdy;
    logic       wr_trig;
    logic [7:0] wfifo_rd_data;
    logic [4:0] fifo_cnt;
    logic       ovf_err;
    logic       udf_err;

    int         n_cmp = 0;
    int         n_err = 0;
    int         trig_cnt = 0;
    int         base;
    int         guard;
    logic [7:0] model_q[$];

    sdram_wfifo_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .din_vld       (din_vld),
        .din           (din),
        .din_rdy       (din_rdy),
        .wr_trig       (wr_trig),
        .wfifo_rd_en   (wfifo_rd_en),
        .wfifo_rd_data (wfifo_rd_data),
        .fifo_cnt      (fifo_cnt),
        .ovf_err       (ovf_err),
        .udf_err       (udf_err)
    );

    always #5 clk = ~clk;

    // Count trigger pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && wr_trig) trig_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push n bytes start, start+step, ...; model accepts only while not full.
    task automatic push_seq(input logic [7:0] start, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) begin
            din_vld = 1'b1;
            din     = start + step * 8'(i);
            if (model_q.size() < 16) model_q.push_back(din);
            @(negedge clk);
        end
        din_vld = 1'b0;
    endtask

    // Pop n bytes back to back, checking each one the cycle after rd_en.
    task automatic pop_n(input int n, input bit chk_trig);
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            wfifo_rd_en = 1'b1;
            @(negedge clk);
            exp = model_q.pop_front();
            chk("rd_data", 32'(wfifo_rd_data), 32'(exp));
            if (chk_trig) chk("no_trig_in_busy", 32'(wr_trig), 32'd0);
        end
        wfifo_rd_en = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_din_rdy", 32'(din_rdy), 32'd1);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_trig", 32'(wr_trig), 32'd0);
        chk("rst_rd_data", 32'(wfifo_rd_data), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_udf", 32'(udf_err), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));

        // Three bytes: below burst size, no trigger
        push_seq(8'h11, 8'h11, 3);
        chk("cnt3", 32'(fifo_cnt), 32'd3);
        @(negedge clk);
        chk("no_trig_cnt3", 32'(wr_trig), 32'd0);
        // Fourth byte: trigger two cycles after it is driven
        push_seq(8'h44, 8'h00, 1);
        chk("cnt4", 32'(fifo_cnt), 32'd4);
        chk("trig_not_yet", 32'(wr_trig), 32'd0);
        @(negedge clk);
        chk("trig_pulse", 32'(wr_trig), 32'd1);
        @(negedge clk);
        chk("trig_one_cycle", 32'(wr_trig), 32'd0);
        chk("state_busy", 32'(dut.state_q), 32'(S_BUSY));

        // Drain the burst
        pop_n(4, 1'b1);
        chk("burst_done_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("burst_done_cnt", 32'(fifo_cnt), 32'd0);
        chk("trig_total1", 32'(trig_cnt), 32'd1);

        // Underflow: data holds, count stays zero
        wfifo_rd_en = 1'b1;
        @(negedge clk);
        wfifo_rd_en = 1'b0;
        chk("udf_set", 32'(udf_err), 32'd1);
        chk("udf_data_hold", 32'(wfifo_rd_data), 32'h44);
        chk("udf_cnt", 32'(fifo_cnt), 32'd0);
        @(negedge clk);
        chk("udf_sticky", 32'(udf_err), 32'd1);

        // Two rounds of 8 bytes, each served as two bursts; second round wraps
        for (int r = 0; r < 2; r++) begin
            base = trig_cnt;
            push_seq(8'hA0 + 8'(r * 8), 8'h01, 8);
            chk("two_burst_cnt8", 32'(fifo_cnt), 32'd8);
            chk("two_burst_trig1", 32'(trig_cnt), 32'(base + 1));
            chk("two_burst_busy", 32'(dut.state_q), 32'(S_BUSY));
            pop_n(4, 1'b1);
            guard = 0;
            while (!wr_trig && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            chk("second_trig_seen", 32'(wr_trig), 32'd1);
            @(negedge clk);
            pop_n(4, 1'b1);
            chk("two_burst_empty", 32'(fifo_cnt), 32'd0);
            chk("two_burst_idle", 32'(dut.state_q), 32'(S_IDLE));
            chk("two_burst_trig2", 32'(trig_cnt), 32'(base + 2));
        end

        // Overflow: 16 accepted, 17th dropped, flag sticky, order preserved
        push_seq(8'h01, 8'h01, 16);
        chk("full_din_rdy", 32'(din_rdy), 32'd0);
        chk("full_cnt", 32'(fifo_cnt), 32'd16);
        chk("no_ovf_yet", 32'(ovf_err), 32'd0);
        push_seq(8'h11, 8'h00, 1);
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_cnt", 32'(fifo_cnt), 32'd16);
        repeat (2) @(negedge clk);
        chk("ovf_sticky", 32'(ovf_err), 32'd1);
        pop_n(16, 1'b0);
        chk("drain_cnt", 32'(fifo_cnt), 32'd0);
        chk("drain_din_rdy", 32'(din_rdy), 32'd1);

        // Synchronous-style reset to clear flags and the half-served burst
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        @(negedge clk);
        chk("rst2_ovf", 32'(ovf_err), 32'd0);
        chk("rst2_udf", 32'(udf_err), 32'd0);

        // Asynchronous reset mid-burst
        push_seq(8'h51, 8'h01, 4);
        @(negedge clk);
        chk("mid_trig", 32'(wr_trig), 32'd1);
        @(negedge clk);
        pop_n(3, 1'b1);
        chk("mid_burst_cnt", 32'(dut.burst_cnt_q), 32'd3);
        chk("mid_fifo_cnt", 32'(fifo_cnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(fifo_cnt), 32'd0);
        chk("arst_din_rdy", 32'(din_rdy), 32'd1);
        chk("arst_trig", 32'(wr_trig), 32'd0);
        chk("arst_rd_data", 32'(wfifo_rd_data), 32'd0);
        chk("arst_state", 32'(dut.state_q), 32'(S_IDLE));
        chk("arst_burst_cnt", 32'(dut.burst_cnt_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        @(negedge clk);

        // Fresh burst after reset
        push_seq(8'h61, 8'h01, 4);
        chk("fresh_no_trig_yet", 32'(wr_trig), 32'd0);
        @(negedge clk);
        chk("fresh_trig", 32'(wr_trig), 32'd1);
        @(negedge clk);
        pop_n(4, 1'b1);
        chk("fresh_idle", 32'(dut.state_q), 32'(S_IDLE));
        chk("fresh_cnt", 32'(fifo_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
